div_seq: RTL
============

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have parameter N, default 10, giving the divisor, quotient and remainder width; the dividend width is 2*N.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; accepted only when busy=0.
REQ-005 The block SHALL have port z, input, 2*N bits: unsigned dividend; same width and meaning as the product output of the cascade multiplier.
REQ-006 The block SHALL have port y, input, N bits: unsigned divisor.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when results are valid.
REQ-009 The block SHALL have port q, output, N bits: quotient.
REQ-010 The block SHALL have port r, output, N bits: remainder.
REQ-011 The block SHALL have port ovf, output, 1 bit: quotient does not fit in N bits; divisor is nonzero.
REQ-012 The block SHALL have port dz, output, 1 bit: divisor is zero.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE; busy=1 only in RUN.
REQ-014 When start=1 in IDLE or DONE, z and y SHALL be registered on that edge (the accept edge); start in RUN SHALL be ignored, with inputs not sampled.
REQ-015 On accept with y==0, the FSM SHALL go to DONE with dz=1, ovf=0, q=all ones and r=0.
REQ-016 On accept with y!=0 and z[2N-1:N]>=y, the FSM SHALL go to DONE with ovf=1, dz=0, q=all ones and r=0.
REQ-017 On any other accept, the FSM SHALL go to RUN with iteration counter = N-1, partial remainder = {1'b0, z[2N-1:N]} (N+1 bits), and quotient shift register = z[N-1:0].
REQ-018 Each RUN cycle SHALL perform one restoring step:
- shift left the pair {remainder, quotient}, bringing the next dividend bit into the remainder LSB;
- if remainder >= y, subtract y and set quotient LSB=1, else set quotient LSB=0.
REQ-019 RUN SHALL last exactly N cycles; after the step with counter==0, the FSM SHALL go to DONE.
REQ-020 done SHALL be high for exactly the one cycle the FSM is in DONE:
- normal case: N+1 cycles after the accept edge;
- dz/ovf cases: 1 cycle after the accept edge.
REQ-021 q, r, ovf and dz SHALL update only on entry to DONE and hold until the next entry to DONE.
REQ-022 For a normal division, q*y + r SHALL equal z exactly and r < y SHALL hold.
REQ-023 In DONE without start, the FSM SHALL return to IDLE; in DONE with start, the new operation SHALL be accepted (back-to-back, no idle cycle).
REQ-024 The arithmetic SHALL be unsigned, with no rounding and no sign handling.

Reset
REQ-025 When rst=1 at a clock edge, the block SHALL go to IDLE and clear busy, done, q, r, ovf, dz and the counter to 0.
REQ-026 rst SHALL take priority over start and abort any in-progress RUN; no done is produced for the aborted operation.

Structure
REQ-027 Package div_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default width constant; div_seq SHALL import it.
REQ-028 One combinational sub-module div_step SHALL implement a single restoring step:
- inputs: remainder (N+1 bits), next dividend bit, y;
- outputs: new remainder and quotient bit;
- div_seq SHALL instantiate it once and iterate it.

Verification (N=10)
REQ-029 Normal division: z=1000, y=7, start pulse -> done 11 cycles later; q=142, r=6, ovf=0, dz=0; busy high 10 cycles.
REQ-030 Boundary division: z=1047551, y=1023 -> q=1023, r=1022; then z=100000, y=500 -> q=200, r=0.
REQ-031 Overflow: z=7168, y=7 -> done 1 cycle after accept, ovf=1, q=1023, r=0. Divide-by-zero: y=0, z=5 -> dz=1, ovf=0.
REQ-032 Round trip: 10 pairs x, y (y!=0, random) fed through mul_cascode; its z drives div_seq with y -> q=x, r=0 every time.
REQ-033 Protocol:
- start held high through RUN -> one result only; inputs changed mid-RUN do not affect the result;
- start asserted during DONE -> next operation accepted and busy rises next cycle.
REQ-034 Reset: rst pulsed at RUN cycle 5 -> next cycle busy=0, done=0, q=0, r=0; no done pulse follows; a subsequent start gives a correct result.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the FSM state encoding and the default operand width.
package div_pkg;

    localparam int DIV_N = 10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
// rem/bit_in/y in; rem_nx (new partial remainder) and q_bit out.
module div_step #(
    parameter int N = 10
) (
    input  logic [N:0]   rem,
    input  logic         bit_in,
    input  logic [N-1:0] y,
    output logic [N:0]   rem_nx,
    output logic         q_bit
);

    logic [N+1:0] sh;
    logic [N+1:0] diff;
    logic [N+1:0] rem_wide;
    logic         unused_top;

    // rem < y holds between steps, so the shifted value never needs
    // more than N+1 bits; the extra top bit is carried only for safety.
    assign sh       = {rem, bit_in};
    assign diff     = sh - {2'b00, y};
    assign q_bit    = (sh >= {2'b00, y});
    assign rem_wide = q_bit ? diff : sh;
    assign rem_nx   = rem_wide[N:0];
    assign unused_top = rem_wide[N+1];

endmodule

// File: rtl/div_seq.sv
// Sequential unsigned divider: 2N-bit z / N-bit y, one bit per cycle.
// Ports: clk, rst (sync high), start, z, y -> busy, done, q, r, ovf, dz.
module div_seq
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] z,
    input  logic [N-1:0]   y,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   q,
    output logic [N-1:0]   r,
    output logic           ovf,
    output logic           dz
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t         state;
    state_t         state_nx;
    logic [CW-1:0]  cnt;
    logic [N:0]     rem;
    logic [N-1:0]   quo;
    logic [N-1:0]   yr;

    logic [N-1:0]   zh;
    logic [N-1:0]   zl;
    logic           accept;
    logic           finish;
    logic           y_zero;
    logic           q_big;

    logic [N:0]     step_rem;
    logic           step_q;
    logic [N-1:0]   quo_nx;

    assign zh     = z[2*N-1:N];
    assign zl     = z[N-1:0];
    assign y_zero = (y == '0);
    // Quotient fits in N bits only if the upper dividend half is below y.
    assign q_big  = (zh >= y);
    assign quo_nx = {quo[N-2:0], step_q};

    div_step #(
        .N(N)
    ) u_step (
        .rem    (rem),
        .bit_in (quo[N-1]),
        .y      (yr),
        .rem_nx (step_rem),
        .q_bit  (step_q)
    );

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        finish   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = (y_zero || q_big) ? DONE : RUN;
                end else if (state == DONE) begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    finish   = 1'b1;
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            yr    <= '0;
            q     <= '0;
            r     <= '0;
            ovf   <= 1'b0;
            dz    <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                yr  <= y;
                cnt <= CW'(N - 1);
                rem <= {1'b0, zh};
                quo <= zl;
                if (y_zero) begin
                    dz  <= 1'b1;
                    ovf <= 1'b0;
                    q   <= '1;
                    r   <= '0;
                end else if (q_big) begin
                    dz  <= 1'b0;
                    ovf <= 1'b1;
                    q   <= '1;
                    r   <= '0;
                end
            end else if (state == RUN) begin
                rem <= step_rem;
                quo <= quo_nx;
                cnt <= cnt - 1'b1;
                if (finish) begin
                    q   <= quo_nx;
                    r   <= step_rem[N-1:0];
                    ovf <= 1'b0;
                    dz  <= 1'b0;
                end
            end
        end
    end

endmodule
